// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared state type and defaults for the audio clip scheduler
package audio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_OUT,
    ST_WAIT_TICK
  } clip_state_t;

  localparam int DIV_DEFAULT   = 10000;
  localparam int SHIFT_DEFAULT = 14;
  localparam int ID_W          = 2;

endpackage

// File: rtl/audio_clip_sched_prio_arb.sv
// rtl/audio_clip_sched_prio_arb.sv - fixed-priority encoder, lowest index wins
module prio_arb
  import audio_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  output logic             grant_valid,
  output logic [ID_W-1:0]  grant_id
);

  always_comb begin
    grant_valid = |req;
    grant_id    = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) grant_id = ID_W'(i);
    end
  end

endmodule

// File: rtl/audio_clip_sched.sv
// rtl/audio_clip_sched.sv - request-driven clip player sharing one sample ROM and audio FIFO
module audio_clip_sched
  import audio_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ADDR_W   = 16,
  parameter int SAMPLE_W = 19,
  parameter int DIV      = DIV_DEFAULT,
  parameter int ROM_LAT  = 2,
  parameter int SHIFT    = SHIFT_DEFAULT
) (
  input  logic                    CLOCK_50,
  input  logic                    resetn,
  input  logic [N_REQ-1:0]        req,
  input  logic                    stop,
  input  logic [N_REQ*ADDR_W-1:0] clip_start,
  input  logic [N_REQ*ADDR_W-1:0] clip_end,
  output logic [ADDR_W-1:0]       rom_addr,
  input  logic [SAMPLE_W-1:0]     rom_q,
  input  logic                    audio_out_allowed,
  output logic                    write_audio_out,
  output logic [31:0]             audio_out_data,
  output logic                    busy,
  output logic [ID_W-1:0]         active_id,
  output logic                    done,
  output logic [7:0]              drop_cnt
);

  localparam int TICK_W = $clog2(DIV);
  localparam int LAT_W  = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  clip_state_t         state, state_n;
  logic [N_REQ-1:0]    pending;
  logic [TICK_W-1:0]   tick_cnt;
  logic [LAT_W-1:0]    lat_cnt;
  logic [SAMPLE_W-1:0] sample_r;

  logic [ADDR_W-1:0] start_a [N_REQ];
  logic [ADDR_W-1:0] end_a   [N_REQ];

  logic             grant_valid;
  logic [ID_W-1:0]  grant_id;
  logic             grant_en;
  logic [N_REQ-1:0] grant_mask;
  logic             tick_last;
  logic             lat_last;
  logic             last_addr;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign start_a[i] = clip_start[i*ADDR_W +: ADDR_W];
    assign end_a[i]   = clip_end[i*ADDR_W +: ADDR_W];
  end

  prio_arb #(.N_REQ(N_REQ)) u_arb (
    .req        (pending),
    .grant_valid(grant_valid),
    .grant_id   (grant_id)
  );

  assign grant_en   = (state == ST_IDLE) && grant_valid && !stop;
  assign grant_mask = grant_en ? (N_REQ'(1) << grant_id) : '0;
  assign tick_last  = (tick_cnt == TICK_W'(DIV - 1));
  assign lat_last   = (lat_cnt == LAT_W'(ROM_LAT - 1));
  // start > end also terminates after the first sample
  assign last_addr  = (rom_addr >= end_a[active_id]);

  assign busy           = (state != ST_IDLE);
  assign audio_out_data = 32'(sample_r) << SHIFT;

  always_comb begin
    state_n         = state;
    write_audio_out = 1'b0;
    done            = 1'b0;
    if (stop) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:      if (grant_valid) state_n = ST_FETCH;
        ST_FETCH:     if (lat_last) state_n = ST_WAIT_OUT;
        ST_WAIT_OUT: begin
          if (audio_out_allowed) begin
            write_audio_out = 1'b1;
            if (last_addr) begin
              done    = 1'b1;
              state_n = ST_IDLE;
            end else begin
              state_n = ST_WAIT_TICK;
            end
          end
        end
        ST_WAIT_TICK: if (tick_last) state_n = ST_FETCH;
        default:      state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (!resetn) begin
      state     <= ST_IDLE;
      pending   <= '0;
      rom_addr  <= '0;
      active_id <= '0;
      tick_cnt  <= '0;
      lat_cnt   <= '0;
      sample_r  <= '0;
      drop_cnt  <= '0;
    end else begin
      state <= state_n;

      // a req coincident with stop is dropped along with the queue
      if (stop) pending <= '0;
      else      pending <= (pending & ~grant_mask) | req;

      if (grant_en) begin
        rom_addr  <= start_a[grant_id];
        active_id <= grant_id;
        tick_cnt  <= '0;
      end else begin
        if (state != ST_IDLE) tick_cnt <= tick_last ? '0 : tick_cnt + 1'b1;
        if (write_audio_out && !done) rom_addr <= rom_addr + 1'b1;
      end

      if (state == ST_FETCH && !lat_last) lat_cnt <= lat_cnt + 1'b1;
      else                                lat_cnt <= '0;

      if (state == ST_FETCH && lat_last && !stop) sample_r <= rom_q;

      // a tick landing while still fetching or blocked on the FIFO is a missed slot
      if ((state == ST_FETCH || state == ST_WAIT_OUT) && tick_last && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_audio_clip_sched.sv
// tb/tb_audio_clip_sched.sv - directed self-checking bench for audio_clip_sched
module tb_audio_clip_sched;

  localparam int DIVP = 16;

  logic        CLOCK_50 = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  req = '0;
  logic        stop = 1'b0;
  logic [63:0] clip_start = '0;
  logic [63:0] clip_end = '0;
  logic [15:0] rom_addr;
  logic [18:0] rom_q = '0;
  logic        audio_out_allowed = 1'b1;
  logic        write_audio_out;
  logic [31:0] audio_out_data;
  logic        busy;
  logic [1:0]  active_id;
  logic        done;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  logic prev_done = 1'b0;

  int          wr_cyc[$];
  logic [31:0] wr_data[$];
  logic        wr_done[$];
  logic [1:0]  wr_id[$];

  typedef struct {
    int          id;
    logic [15:0] s;
    logic [15:0] e;
    int          n;
    logic [31:0] last;
  } vec_t;

  vec_t vecs[4];

  audio_clip_sched #(.DIV(DIVP), .ROM_LAT(2)) dut (
    .CLOCK_50         (CLOCK_50),
    .resetn           (resetn),
    .req              (req),
    .stop             (stop),
    .clip_start       (clip_start),
    .clip_end         (clip_end),
    .rom_addr         (rom_addr),
    .rom_q            (rom_q),
    .audio_out_allowed(audio_out_allowed),
    .write_audio_out  (write_audio_out),
    .audio_out_data   (audio_out_data),
    .busy             (busy),
    .active_id        (active_id),
    .done             (done),
    .drop_cnt         (drop_cnt)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // ROM returns its own address one clock after the address is registered
  always @(posedge CLOCK_50) begin
    cyc   <= cyc + 1;
    rom_q <= {3'b000, rom_addr};
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (write_audio_out) begin
      wr_cyc.push_back(cyc);
      wr_data.push_back(audio_out_data);
      wr_done.push_back(done);
      wr_id.push_back(active_id);
      chk("wr_allowed", audio_out_allowed, 1);
    end
    if (done) begin
      done_cnt++;
      chk("done_with_write", write_audio_out, 1);
    end
    if (prev_done) chk("busy_after_done", busy, 0);
    prev_done = done;
  end

  task automatic clear_log();
    wr_cyc.delete();
    wr_data.delete();
    wr_done.delete();
    wr_id.delete();
  endtask

  task automatic set_clip(input int id, input logic [15:0] s, input logic [15:0] e);
    clip_start[id*16 +: 16] = s;
    clip_end[id*16 +: 16]   = e;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    int n = 0;
    while (done_cnt < target && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk({name, "_timeout"}, 32'(n < budget), 1);
    repeat (2) @(negedge CLOCK_50);
  endtask

  task automatic wait_write(input int budget, output int w);
    int n = 0;
    @(negedge CLOCK_50);
    while (!write_audio_out && n < budget) begin
      @(negedge CLOCK_50);
      n++;
    end
    chk("first_write_timeout", 32'(n < budget), 1);
    w = cyc;
  endtask

  task automatic do_reset();
    @(posedge CLOCK_50); #1;
    resetn = 1'b0;
    @(posedge CLOCK_50); #1;
    resetn = 1'b1;
  endtask

  task automatic play_clip(input vec_t v, input logic [7:0] exp_drop);
    int t;
    int base;
    set_clip(v.id, v.s, v.e);
    clear_log();
    base = done_cnt;
    @(posedge CLOCK_50); #1;
    req = 4'b0001 << v.id;
    t = cyc;
    @(posedge CLOCK_50); #1;
    req = '0;
    wait_done(base + 1, 300, "clip");
    chk("n_writes", wr_cyc.size(), v.n);
    for (int k = 0; k < wr_cyc.size() && k < v.n; k++) begin
      chk("wr_data", wr_data[k], (32'(v.s) + 32'(k)) << 14);
      chk("wr_id", wr_id[k], v.id);
      chk("wr_done", wr_done[k], 32'(k == v.n - 1));
      if (k == 0) chk("first_latency", wr_cyc[0], t + 4);
      else        chk("spacing", wr_cyc[k] - wr_cyc[k-1], DIVP);
    end
    if (wr_data.size() > 0) chk("last_data", wr_data[wr_data.size()-1], v.last);
    chk("drop_cnt", drop_cnt, exp_drop);
    chk("idle_after", busy, 0);
  endtask

  initial begin : main
    int t;
    int w1;
    int base;
    int bc;
    int exp_off[4];
    logic [31:0] exp_two[3];
    vec_t v;

    vecs[0] = '{2, 16'd100,    16'd102,    3, 32'd1671168};
    vecs[1] = '{0, 16'd50,     16'd40,     1, 32'd819200};
    vecs[2] = '{3, 16'd7,      16'd7,      1, 32'd114688};
    vecs[3] = '{1, 16'hFFFE,   16'hFFFF,   2, 32'h3FFFC000};
    exp_off = '{0, 48, 64, 80};
    exp_two = '{32'd163840, 32'd180224, 32'd327680};

    repeat (3) @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("rst_busy", busy, 0);
    chk("rst_write", write_audio_out, 0);
    chk("rst_done", done, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_data", audio_out_data, 0);
    chk("rst_active_id", active_id, 0);
    chk("rst_drop", drop_cnt, 0);
    resetn = 1'b1;

    for (int i = 0; i < 4; i++) play_clip(vecs[i], 8'd0);

    // simultaneous req[3] and req[1]: lower index first, next grant right after IDLE
    set_clip(1, 16'd10, 16'd11);
    set_clip(3, 16'd20, 16'd20);
    clear_log();
    base = done_cnt;
    @(posedge CLOCK_50); #1;
    req = 4'b1010;
    t = cyc;
    @(posedge CLOCK_50); #1;
    req = '0;
    wait_done(base + 2, 400, "two_req");
    chk("two_n", wr_cyc.size(), 3);
    if (wr_cyc.size() == 3) begin
      for (int k = 0; k < 3; k++) chk("two_data", wr_data[k], exp_two[k]);
      chk("two_id0", wr_id[0], 1);
      chk("two_id1", wr_id[1], 1);
      chk("two_id2", wr_id[2], 3);
      chk("two_done1", wr_done[1], 1);
      chk("two_lat", wr_cyc[0], t + 4);
      chk("two_next_grant", wr_cyc[2], wr_cyc[1] + 4);
    end

    // FIFO blocked for 40 cycles across two tick boundaries
    do_reset();
    set_clip(0, 16'd200, 16'd203);
    clear_log();
    base = done_cnt;
    @(posedge CLOCK_50); #1;
    req = 4'b0001;
    @(posedge CLOCK_50); #1;
    req = '0;
    wait_write(50, w1);
    while (cyc < w1 + 8) begin
      @(posedge CLOCK_50); #1;
    end
    audio_out_allowed = 1'b0;
    repeat (40) @(posedge CLOCK_50);
    #1;
    audio_out_allowed = 1'b1;
    wait_done(base + 1, 300, "blocked");
    chk("blk_n", wr_cyc.size(), 4);
    for (int k = 0; k < wr_cyc.size() && k < 4; k++) begin
      chk("blk_data", wr_data[k], (32'd200 + 32'(k)) << 14);
      chk("blk_cyc", wr_cyc[k] - w1, exp_off[k]);
    end
    chk("blk_drop", drop_cnt, 2);

    // stop in WAIT_TICK with req[0] pending and req[1] arriving together with stop
    set_clip(2, 16'd100, 16'd105);
    clear_log();
    base = done_cnt;
    @(posedge CLOCK_50); #1;
    req = 4'b0100;
    @(posedge CLOCK_50); #1;
    req = '0;
    wait_write(50, w1);
    @(posedge CLOCK_50); #1;
    @(posedge CLOCK_50); #1;
    req = 4'b0001;
    @(posedge CLOCK_50); #1;
    req  = 4'b0010;
    stop = 1'b1;
    @(negedge CLOCK_50);
    chk("stop_busy_before", busy, 1);
    chk("stop_no_write", write_audio_out, 0);
    chk("stop_no_done", done, 0);
    @(posedge CLOCK_50); #1;
    req  = '0;
    stop = 1'b0;
    @(negedge CLOCK_50);
    chk("stop_idle", busy, 0);
    chk("stop_pending", dut.pending, 0);
    bc = 0;
    repeat (60) begin
      @(negedge CLOCK_50);
      if (busy) bc++;
    end
    chk("stop_stays_idle", bc, 0);
    chk("stop_writes", wr_cyc.size(), 1);
    chk("stop_done_cnt", done_cnt, base);

    // reset asserted while FETCH is in progress
    set_clip(1, 16'd300, 16'd302);
    clear_log();
    @(posedge CLOCK_50); #1;
    req = 4'b0010;
    @(posedge CLOCK_50); #1;
    req = '0;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    chk("mid_fetch_busy", busy, 1);
    chk("mid_fetch_addr", rom_addr, 300);
    resetn = 1'b0;
    @(negedge CLOCK_50);
    chk("mrst_busy", busy, 0);
    chk("mrst_write", write_audio_out, 0);
    chk("mrst_done", done, 0);
    chk("mrst_rom_addr", rom_addr, 0);
    chk("mrst_data", audio_out_data, 0);
    chk("mrst_active_id", active_id, 0);
    chk("mrst_drop", drop_cnt, 0);
    chk("mrst_pending", dut.pending, 0);
    resetn = 1'b1;
    chk("mrst_no_writes", wr_cyc.size(), 0);
    v = '{1, 16'd300, 16'd302, 3, 32'd4947968};
    play_clip(v, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
